// File: rtl/best_scan_pkg.sv
// best_scan_pkg: shared types and constants for the post-run best-distance scanner.
//   total_data_t : one total-distance word as it travels along the array shift chain
//   scan_state_t : scanner FSM states
//   ST_*         : the same states as plain 2-bit constants, for code that keeps
//                  its state register as logic
//   DIST_W       : width of a distance word, derived from total_data_t
package best_scan_pkg;

  typedef logic [31:0] total_data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } scan_state_t;

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_PEND = 2'(PEND);
  localparam logic [1:0] ST_SCAN = 2'(SCAN);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  localparam int DIST_W = $bits(total_data_t);

  // Host shifts must be held off while a scan is waiting or is in progress.
  function automatic logic state_busy(input logic [1:0] state);
    return (state == ST_PEND) || (state == ST_SCAN);
  endfunction

endpackage

// File: rtl/best_scan_if.sv
// best_scan_if: total-distance shift chain between the scanner and the array.
//   dist_shift : shift strobe toward the array
//   dist_wdata : word written into the chain tail on a shift
//   dist_rdata : word at the chain head (combinational from the array)
//   parity     : scanner's mirror of the array's or/tw chain select
// Modports: master = scanner side, slave = array side.
interface best_scan_if #(parameter int dist_w = best_scan_pkg::DIST_W);
  logic              dist_shift;
  logic [dist_w-1:0] dist_wdata;
  logic [dist_w-1:0] dist_rdata;
  logic              parity;

  modport master (output dist_shift, output dist_wdata, output parity, input dist_rdata);
  modport slave  (input dist_shift, input dist_wdata, input parity, output dist_rdata);
endinterface

// File: rtl/best_scan_min_tracker.sv
// min_tracker: holds a minimum value and the index it came from.
//   clk, reset : clock and synchronous active-high reset
//   clear      : forget the held value (min_val all-ones, valid 0)
//   load       : take value/idx unconditionally (wins over clear)
//   update     : take value/idx only if nothing is held or value is strictly less
//   value, idx : candidate word and its index
//   min_val, min_idx, valid : held minimum, its index, and whether one is held
// Used both for the per-scan running minimum and for the all-time best.
module min_tracker
  import best_scan_pkg::*;
#(
  parameter int dist_w = DIST_W,
  parameter int idx_w  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              update,
  input  logic [dist_w-1:0] value,
  input  logic [idx_w-1:0]  idx,
  output logic [dist_w-1:0] min_val,
  output logic [idx_w-1:0]  min_idx,
  output logic              valid
);

  logic better;

  // Strictly-less keeps the earliest index on ties.
  assign better = !valid || (value < min_val);

  // Load beats clear so a clear coinciding with a new result still captures it.
  always_ff @(posedge clk) begin
    if (reset) begin
      min_val <= '1;
      min_idx <= '0;
      valid   <= 1'b0;
    end else if (load) begin
      min_val <= value;
      min_idx <= idx;
      valid   <= 1'b1;
    end else if (update && better) begin
      min_val <= value;
      min_idx <= idx;
      valid   <= 1'b1;
    end else if (clear) begin
      min_val <= '1;
      min_idx <= '0;
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/best_scan.sv
// best_scan: after a run, rotates the total-distance chain once through itself
// and reports the smallest word of that pass plus an all-time best.
//   clk, reset            : clock, synchronous active-high reset
//   running               : array run in progress
//   auto_en               : start a scan on the falling edge of running
//   scan_start            : one-cycle software scan request
//   best_clear            : one-cycle clear of the all-time best
//   host_shift/host_wdata : host chain access, passed through when idle
//   chain                 : shift chain to the array (best_scan_if.master)
//   scan_busy             : scan pending or in progress
//   scan_done             : one-cycle pulse when results update
//   last_min/last_idx     : minimum of the latest scan and its word index
//   best_dist/best_idx/best_valid : all-time minimum
//   scan_count            : completed scans, saturating
//   host_shift_err        : sticky, a host shift was dropped while busy
module best_scan
  import best_scan_pkg::*;
#(
  parameter int replica_num = 32,
  parameter int dist_w      = DIST_W,
  parameter int idx_w       = $clog2(2 * replica_num)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              running,
  input  logic              auto_en,
  input  logic              scan_start,
  input  logic              best_clear,
  input  logic              host_shift,
  input  logic [dist_w-1:0] host_wdata,
  best_scan_if.master       chain,
  output logic              scan_busy,
  output logic              scan_done,
  output logic [dist_w-1:0] last_min,
  output logic [idx_w-1:0]  last_idx,
  output logic [dist_w-1:0] best_dist,
  output logic [idx_w-1:0]  best_idx,
  output logic              best_valid,
  output logic [15:0]       scan_count,
  output logic              host_shift_err
);

  localparam logic [idx_w-1:0] LAST_K = idx_w'(2 * replica_num - 1);

  logic [1:0]        state;
  logic [idx_w-1:0]  k;
  logic              running_d;
  logic              parity;
  logic              trigger;
  logic              in_scan;
  logic [dist_w-1:0] scan_min;
  logic [idx_w-1:0]  scan_idx;
  logic              scan_valid;
  logic              final_take;

  assign trigger   = scan_start | (auto_en & running_d & ~running);
  assign in_scan   = (state == ST_SCAN);
  assign scan_busy = state_busy(state);
  assign scan_done = (state == ST_DONE);

  // While scanning, every word read at the head is written straight back at
  // the tail, so 2N shifts leave the chain exactly as it was.
  assign chain.dist_shift = in_scan ? 1'b1 : (host_shift & ~scan_busy);
  assign chain.dist_wdata = in_scan ? chain.dist_rdata : host_wdata;
  assign chain.parity     = parity;

  // Scan sequencing: a trigger while the array still runs waits in PEND.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      k     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          k <= '0;
          if (trigger) state <= running ? ST_PEND : ST_SCAN;
        end
        ST_PEND: begin
          k <= '0;
          if (!running) state <= ST_SCAN;
        end
        ST_SCAN: begin
          if (k == LAST_K) state <= ST_DONE;
          else             k     <= k + 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) running_d <= 1'b0;
    else       running_d <= running;
  end

  // Mirrors the array's or/tw select, which flips on every shift.
  always_ff @(posedge clk) begin
    if (reset)                 parity <= 1'b0;
    else if (chain.dist_shift) parity <= ~parity;
  end

  always_ff @(posedge clk) begin
    if (reset)                        host_shift_err <= 1'b0;
    else if (host_shift && scan_busy) host_shift_err <= 1'b1;
  end

  min_tracker #(.dist_w(dist_w), .idx_w(idx_w)) u_scan_min (
    .clk     (clk),
    .reset   (reset),
    .clear   (1'b0),
    .load    (in_scan && (k == '0)),
    .update  (in_scan && (k != '0)),
    .value   (chain.dist_rdata),
    .idx     (k),
    .min_val (scan_min),
    .min_idx (scan_idx),
    .valid   (scan_valid)
  );

  // The last word is folded in here rather than in the tracker so the scan
  // result is already stable during the DONE cycle.
  assign final_take = !scan_valid || (chain.dist_rdata < scan_min);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_min <= '0;
      last_idx <= '0;
    end else if (in_scan && (k == LAST_K)) begin
      last_min <= final_take ? chain.dist_rdata : scan_min;
      last_idx <= final_take ? k : scan_idx;
    end
  end

  // A clear landing on DONE wipes the old best and the new result replaces it.
  min_tracker #(.dist_w(dist_w), .idx_w(idx_w)) u_best (
    .clk     (clk),
    .reset   (reset),
    .clear   (best_clear),
    .load    (scan_done && best_clear),
    .update  (scan_done),
    .value   (last_min),
    .idx     (last_idx),
    .min_val (best_dist),
    .min_idx (best_idx),
    .valid   (best_valid)
  );

  always_ff @(posedge clk) begin
    if (reset)                                 scan_count <= '0;
    else if (scan_done && scan_count != 16'hFFFF) scan_count <= scan_count + 16'd1;
  end

endmodule

// File: tb/tb_best_scan.sv
// tb_best_scan: self-checking bench for best_scan with replica_num = 4 (8 words).
// The array is modelled as an 8-word rotating ring; expectations come from a
// plain queue of the chain contents and a running best/count model.
module tb_best_scan;
  import best_scan_pkg::*;

  localparam int N2 = 8;

  logic        clk = 1'b0;
  logic        reset, running, auto_en, scan_start, best_clear, host_shift;
  logic [31:0] host_wdata;
  logic        scan_busy, scan_done, best_valid, host_shift_err;
  logic [31:0] last_min, best_dist;
  logic [2:0]  last_idx, best_idx;
  logic [15:0] scan_count;

  best_scan_if #(.dist_w(32)) dif ();

  best_scan #(.replica_num(4)) dut (
    .clk(clk), .reset(reset), .running(running), .auto_en(auto_en),
    .scan_start(scan_start), .best_clear(best_clear), .host_shift(host_shift),
    .host_wdata(host_wdata), .chain(dif), .scan_busy(scan_busy), .scan_done(scan_done),
    .last_min(last_min), .last_idx(last_idx), .best_dist(best_dist), .best_idx(best_idx),
    .best_valid(best_valid), .scan_count(scan_count), .host_shift_err(host_shift_err)
  );

  always #5 clk = ~clk;

  // Array chain model: rotating ring, head word visible combinationally.
  logic [31:0] ring [N2];
  logic [2:0]  ptr = '0;
  int          shift_cnt = 0;
  assign dif.dist_rdata = ring[ptr];

  always @(posedge clk) begin
    if (dif.dist_shift) begin
      ring[ptr] <= dif.dist_wdata;
      ptr       <= ptr + 3'd1;
      shift_cnt <= shift_cnt + 1;
    end
  end

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] chain_q [$];
  logic [31:0] pre [N2];
  logic [31:0] exp_bd;
  logic [2:0]  exp_bi;
  logic        exp_bv, exp_err, exp_parity;
  logic [15:0] exp_count;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; running = 1'b0; auto_en = 1'b0; scan_start = 1'b0;
    best_clear = 1'b0; host_shift = 1'b0; host_wdata = '0;
    tick(); tick();
    reset = 1'b0;
    exp_bd = '1; exp_bi = '0; exp_bv = 1'b0; exp_err = 1'b0; exp_parity = 1'b0; exp_count = '0;
  endtask

  task automatic host_write(input logic [31:0] w);
    host_shift = 1'b1; host_wdata = w;
    #1;
    vectors++; if (dif.dist_shift !== 1'b1) begin miscompares++; $display("[TB] FAIL host_pass_shift: got %b, expected 1", dif.dist_shift); end
    vectors++; if (dif.dist_wdata !== w) begin miscompares++; $display("[TB] FAIL host_pass_wdata: got %h, expected %h", dif.dist_wdata, w); end
    tick();
    host_shift = 1'b0; host_wdata = '0;
    void'(chain_q.pop_front()); chain_q.push_back(w);
    exp_parity = ~exp_parity;
  endtask

  task automatic host_read(output logic [31:0] r);
    host_shift = 1'b1;
    #1 r = dif.dist_rdata; host_wdata = r;
    #1;
    vectors++; if (dif.dist_wdata !== r) begin miscompares++; $display("[TB] FAIL host_read_wdata: got %h, expected %h", dif.dist_wdata, r); end
    tick();
    host_shift = 1'b0; host_wdata = '0;
    void'(chain_q.pop_front()); chain_q.push_back(r);
    exp_parity = ~exp_parity;
  endtask

  task automatic preload();
    for (int i = 0; i < N2; i++) host_write(pre[i]);
  endtask

  // mode 0: scan_start in idle; mode 1: auto on running fall; mode 2: scan_start while running (PEND)
  task automatic run_scan(input int mode, input bit clear_at_done, input bit start_mid, input bit host_mid);
    logic [31:0] m;
    logic [2:0]  mi;
    int          s0;
    m = chain_q[0]; mi = '0;
    for (int i = 1; i < N2; i++) if (chain_q[i] < m) begin m = chain_q[i]; mi = 3'(i); end
    s0 = shift_cnt;
    case (mode)
      1: begin
        auto_en = 1'b1; running = 1'b1;
        for (int c = 0; c < 20; c++) begin
          #1;
          vectors++; if (scan_busy !== 1'b0 || dif.dist_shift !== 1'b0) begin miscompares++; $display("[TB] FAIL auto_while_running: busy %b shift %b, expected 0 0", scan_busy, dif.dist_shift); end
          tick();
        end
        running = 1'b0;
        #1;
        vectors++; if (scan_busy !== 1'b0 || dif.dist_shift !== 1'b0) begin miscompares++; $display("[TB] FAIL auto_fall_cycle: busy %b shift %b, expected 0 0", scan_busy, dif.dist_shift); end
        tick();
        auto_en = 1'b0;
      end
      2: begin
        running = 1'b1; scan_start = 1'b1;
        #1;
        vectors++; if (scan_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL pend_trigger_busy: got %b, expected 0", scan_busy); end
        tick();
        scan_start = 1'b0;
        for (int c = 0; c < 5; c++) begin
          #1;
          vectors++; if (scan_busy !== 1'b1 || dif.dist_shift !== 1'b0) begin miscompares++; $display("[TB] FAIL pend_hold: busy %b shift %b, expected 1 0", scan_busy, dif.dist_shift); end
          tick();
        end
        running = 1'b0;
        #1;
        vectors++; if (scan_busy !== 1'b1 || dif.dist_shift !== 1'b0) begin miscompares++; $display("[TB] FAIL pend_release: busy %b shift %b, expected 1 0", scan_busy, dif.dist_shift); end
        tick();
      end
      default: begin
        scan_start = 1'b1;
        #1;
        vectors++; if (scan_busy !== 1'b0 || dif.dist_shift !== 1'b0) begin miscompares++; $display("[TB] FAIL start_cycle: busy %b shift %b, expected 0 0", scan_busy, dif.dist_shift); end
        tick();
        scan_start = 1'b0;
      end
    endcase
    for (int c = 1; c <= N2; c++) begin
      if (c == 4) begin scan_start = start_mid; host_shift = host_mid; host_wdata = 32'hDEAD_BEEF; end
      #1;
      vectors++; if (dif.dist_shift !== 1'b1) begin miscompares++; $display("[TB] FAIL scan_shift c%0d: got %b, expected 1", c, dif.dist_shift); end
      vectors++; if (scan_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL scan_busy c%0d: got %b, expected 1", c, scan_busy); end
      vectors++; if (scan_done !== 1'b0) begin miscompares++; $display("[TB] FAIL early_done c%0d: got %b, expected 0", c, scan_done); end
      vectors++; if (dif.dist_wdata !== chain_q[c-1]) begin miscompares++; $display("[TB] FAIL scan_wdata c%0d: got %h, expected %h", c, dif.dist_wdata, chain_q[c-1]); end
      tick();
      scan_start = 1'b0; host_shift = 1'b0; host_wdata = '0;
    end
    if (host_mid) exp_err = 1'b1;
    best_clear = clear_at_done;
    #1;
    vectors++; if (scan_done !== 1'b1) begin miscompares++; $display("[TB] FAIL done_pulse: got %b, expected 1", scan_done); end
    vectors++; if (scan_busy !== 1'b0 || dif.dist_shift !== 1'b0) begin miscompares++; $display("[TB] FAIL done_idle: busy %b shift %b, expected 0 0", scan_busy, dif.dist_shift); end
    vectors++; if (last_min !== m) begin miscompares++; $display("[TB] FAIL last_min: got %0d, expected %0d", last_min, m); end
    vectors++; if (last_idx !== mi) begin miscompares++; $display("[TB] FAIL last_idx: got %0d, expected %0d", last_idx, mi); end
    tick();
    best_clear = 1'b0;
    if (clear_at_done) begin exp_bd = '1; exp_bi = '0; exp_bv = 1'b0; end
    if (!exp_bv || m < exp_bd) begin exp_bd = m; exp_bi = mi; exp_bv = 1'b1; end
    if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    vectors++; if (scan_done !== 1'b0 || scan_busy !== 1'b0 || dif.dist_shift !== 1'b0) begin miscompares++; $display("[TB] FAIL after_done: done %b busy %b shift %b, expected 0 0 0", scan_done, scan_busy, dif.dist_shift); end
    vectors++; if (shift_cnt - s0 !== 8) begin miscompares++; $display("[TB] FAIL shift_count: got %0d, expected 8", shift_cnt - s0); end
    vectors++; if (best_dist !== exp_bd) begin miscompares++; $display("[TB] FAIL best_dist: got %0d, expected %0d", best_dist, exp_bd); end
    vectors++; if (best_idx !== exp_bi) begin miscompares++; $display("[TB] FAIL best_idx: got %0d, expected %0d", best_idx, exp_bi); end
    vectors++; if (best_valid !== exp_bv) begin miscompares++; $display("[TB] FAIL best_valid: got %b, expected %b", best_valid, exp_bv); end
    vectors++; if (scan_count !== exp_count) begin miscompares++; $display("[TB] FAIL scan_count: got %0d, expected %0d", scan_count, exp_count); end
    vectors++; if (host_shift_err !== exp_err) begin miscompares++; $display("[TB] FAIL host_shift_err: got %b, expected %b", host_shift_err, exp_err); end
    vectors++; if (dif.parity !== exp_parity) begin miscompares++; $display("[TB] FAIL parity: got %b, expected %b", dif.parity, exp_parity); end
  endtask

  task automatic test_reset();
    #1;
    vectors++; if (scan_busy !== 1'b0 || scan_done !== 1'b0 || dif.dist_shift !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ctrl: busy %b done %b shift %b, expected 0 0 0", scan_busy, scan_done, dif.dist_shift); end
    vectors++; if (last_min !== 32'd0 || last_idx !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_last: got %h/%0d, expected 0/0", last_min, last_idx); end
    vectors++; if (best_dist !== 32'hFFFF_FFFF || best_idx !== 3'd0 || best_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_best: got %h/%0d/%b, expected ffffffff/0/0", best_dist, best_idx, best_valid); end
    vectors++; if (scan_count !== 16'd0 || host_shift_err !== 1'b0 || dif.parity !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_misc: count %0d err %b parity %b, expected 0 0 0", scan_count, host_shift_err, dif.parity); end
  endtask

  task automatic test_scan_basic();
    pre = '{50, 30, 70, 30, 90, 60, 40, 80};
    preload();
    run_scan(0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_second_scan_and_clear();
    for (int i = 0; i < N2; i++) pre[i] = 32'd100;
    preload();
    run_scan(0, 1'b0, 1'b0, 1'b0);
    best_clear = 1'b1;
    tick();
    best_clear = 1'b0;
    vectors++; if (best_valid !== 1'b0 || best_dist !== 32'hFFFF_FFFF || best_idx !== 3'd0) begin miscompares++; $display("[TB] FAIL best_clear: got %b/%h/%0d, expected 0/ffffffff/0", best_valid, best_dist, best_idx); end
    exp_bd = '1; exp_bi = '0; exp_bv = 1'b0;
  endtask

  task automatic test_auto_and_pend();
    for (int i = 0; i < N2; i++) pre[i] = $urandom_range(0, 1000);
    preload();
    run_scan(1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N2; i++) pre[i] = $urandom;
    preload();
    run_scan(2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_host_shift();
    vectors++; if (host_shift_err !== 1'b0) begin miscompares++; $display("[TB] FAIL err_before: got %b, expected 0", host_shift_err); end
    host_write(32'h1234);
    run_scan(0, 1'b0, 1'b1, 1'b1);
    run_scan(0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random_scans();
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < N2; i++) pre[i] = (n % 2 == 0) ? 32'($urandom_range(0, 12)) : $urandom;
      preload();
      run_scan(0, (n == 0) || ($urandom_range(0, 3) == 0), 1'b0, 1'b0);
    end
  endtask

  task automatic test_recirc();
    logic [31:0] r;
    logic        p0;
    for (int i = 0; i < N2; i++) pre[i] = 32'(i * 1000) + $urandom_range(1, 999);
    preload();
    #1 p0 = dif.parity;
    run_scan(0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N2; i++) begin
      host_read(r);
      vectors++; if (r !== pre[i]) begin miscompares++; $display("[TB] FAIL recirc_word%0d: got %h, expected %h", i, r, pre[i]); end
    end
    vectors++; if (dif.parity !== p0) begin miscompares++; $display("[TB] FAIL recirc_parity: got %b, expected %b", dif.parity, p0); end
  endtask

  task automatic test_reset_mid_scan();
    for (int i = 0; i < N2; i++) pre[i] = $urandom;
    preload();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int c = 1; c <= 3; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++; if (dif.dist_shift !== 1'b0 || scan_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_idle: shift %b busy %b, expected 0 0", dif.dist_shift, scan_busy); end
    for (int c = 0; c < 12; c++) begin
      vectors++; if (scan_done !== 1'b0 || dif.dist_shift !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_quiet c%0d: done %b shift %b, expected 0 0", c, scan_done, dif.dist_shift); end
      tick();
    end
    vectors++; if (scan_count !== 16'd0 || best_valid !== 1'b0 || last_min !== 32'd0) begin miscompares++; $display("[TB] FAIL abort_results: count %0d valid %b last %h, expected 0 0 0", scan_count, best_valid, last_min); end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < N2; i++) chain_q.push_back(32'd0);
    tick();
    do_reset();
    test_reset();
    test_scan_basic();
    test_second_scan_and_clear();
    test_auto_and_pend();
    test_host_shift();
    test_random_scans();
    test_recirc();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
